dt_tree_walker: RTL

Decision-tree traversal engine. It drives the q32_comparator request interface (en/feature/threshold in, go_left/compare_done back) and walks a node table from the root to a leaf. At the leaf it outputs the class. It sits between the CAN feature extractor, which fills the feature register file, and the classification result logic.

---
 rtl/dt_tree_walker.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dt_tree_walker.sv
// Decision-tree traversal engine.
// The block walks a node table from the root (node 0) down to a leaf. At each
// internal node it hands one feature/threshold pair to an external comparator.
// The comparator's go_left answer selects the next child. A walk is aborted
// with error=1 when it performs too many comparisons (this catches cyclic
// tables) or when the comparator does not answer within a fixed number of cycles.
module dt_tree_walker #(
    parameter int N_FEAT      = 8,
    parameter int FIDX_W      = 3,
    parameter int ADDR_W      = 8,
    parameter int CLASS_W     = 4,
    parameter int MAX_DEPTH   = 16,
    parameter int CMP_TIMEOUT = 15,
    localparam int NODE_W     = 1 + CLASS_W + 2 * ADDR_W + FIDX_W + 64
) (
    input  logic                clk,
    input  logic                rst_n,
    // feature register file write port (filled by the feature extractor)
    input  logic                feat_wr_en,
    input  logic [FIDX_W-1:0]   feat_wr_addr,
    input  logic [63:0]         feat_wr_data,
    // walk control and result
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [CLASS_W-1:0]  class_out,
    output logic [4:0]          depth_out,
    output logic                error,
    // node table read port (one cycle read latency)
    output logic [ADDR_W-1:0]   node_addr,
    output logic                node_rd,
    input  logic [NODE_W-1:0]   node_rdata,
    // comparator request/response
    output logic                cmp_en,
    output logic [63:0]         cmp_feature,
    output logic [63:0]         cmp_threshold,
    input  logic                cmp_go_left,
    input  logic                cmp_done
);

    // The timeout counter must be able to hold CMP_TIMEOUT-1.
    localparam int TMO_W = (CMP_TIMEOUT > 1) ? $clog2(CMP_TIMEOUT) : 1;

    // Bit positions of the node word fields, from the MSB down.
    localparam int LEAF_BIT  = NODE_W - 1;
    localparam int CLASS_HI  = NODE_W - 2;
    localparam int LEFT_HI   = 64 + FIDX_W + 2 * ADDR_W - 1;
    localparam int RIGHT_HI  = 64 + FIDX_W + ADDR_W - 1;
    localparam int FIDX_HI   = 64 + FIDX_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_CMP,
        S_REL,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [4:0]            depth_q, depth_d;
    logic [NODE_W-1:0]     node_q, node_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [63:0]           cmp_feature_q, cmp_feature_d;
    logic [63:0]           cmp_threshold_q, cmp_threshold_d;
    logic [CLASS_W-1:0]    class_q, class_d;
    logic [4:0]            depth_out_q, depth_out_d;
    logic                  error_q, error_d;

    logic [63:0]           feat_q [N_FEAT];
    logic [63:0]           feat_d [N_FEAT];

    // Fields of the node word captured in WAIT.
    logic                  nd_leaf;
    logic [CLASS_W-1:0]    nd_class;
    logic [ADDR_W-1:0]     nd_left;
    logic [ADDR_W-1:0]     nd_right;
    logic [FIDX_W-1:0]     nd_fidx;
    logic [63:0]           nd_threshold;

    // Split the captured node word into its fields.
    always_comb begin
        nd_leaf      = node_q[LEAF_BIT];
        nd_class     = node_q[CLASS_HI -: CLASS_W];
        nd_left      = node_q[LEFT_HI -: ADDR_W];
        nd_right     = node_q[RIGHT_HI -: ADDR_W];
        nd_fidx      = node_q[FIDX_HI -: FIDX_W];
        nd_threshold = node_q[63:0];
    end

    // Feature register file. A write is accepted in any state, including
    // in the middle of a walk. The comparator operand is copied out in
    // DECODE, so a later write does not disturb a comparison in flight.
    generate
        for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_feat
            // Next value of one feature register.
            always_comb begin
                feat_d[gi] = feat_q[gi];
                if (feat_wr_en && (feat_wr_addr == FIDX_W'(gi))) begin
                    feat_d[gi] = feat_wr_data;
                end
            end

            // Storage for one feature register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    feat_q[gi] <= '0;
                end else begin
                    feat_q[gi] <= feat_d[gi];
                end
            end
        end
    endgenerate

    // Walk sequencer: next state, datapath updates and result capture.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        depth_d         = depth_q;
        node_d          = node_q;
        tmo_d           = tmo_q;
        cmp_feature_d   = cmp_feature_q;
        cmp_threshold_d = cmp_threshold_q;
        class_d         = class_q;
        depth_out_d     = depth_out_q;
        error_d         = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    depth_d = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                node_d  = node_rdata;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (nd_leaf) begin
                    class_d     = nd_class;
                    error_d     = 1'b0;
                    depth_out_d = depth_q;
                    state_d     = S_DONE;
                end else if (depth_q == 5'(MAX_DEPTH)) begin
                    // The comparison budget is used up: this is most likely a cycle.
                    class_d     = '0;
                    error_d     = 1'b1;
                    depth_out_d = depth_q;
                    state_d     = S_DONE;
                end else begin
                    cmp_feature_d   = feat_q[nd_fidx];
                    cmp_threshold_d = nd_threshold;
                    tmo_d           = '0;
                    state_d         = S_CMP;
                end
            end

            S_CMP: begin
                if (cmp_done) begin
                    // Child addresses wrap naturally at ADDR_W bits.
                    addr_d  = cmp_go_left ? nd_left : nd_right;
                    depth_d = depth_q + 5'd1;
                    state_d = S_REL;
                end else if (tmo_q == TMO_W'(CMP_TIMEOUT - 1)) begin
                    // The request has been held for CMP_TIMEOUT cycles with no answer.
                    class_d     = '0;
                    error_d     = 1'b1;
                    depth_out_d = depth_q;
                    state_d     = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_REL: begin
                // Stay here until the comparator drops done, so that a stale
                // done is not taken as the answer to the next request.
                if (!cmp_done) begin
                    state_d = S_FETCH;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers. Every register returns to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            depth_q         <= '0;
            node_q          <= '0;
            tmo_q           <= '0;
            cmp_feature_q   <= '0;
            cmp_threshold_q <= '0;
            class_q         <= '0;
            depth_out_q     <= '0;
            error_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            depth_q         <= depth_d;
            node_q          <= node_d;
            tmo_q           <= tmo_d;
            cmp_feature_q   <= cmp_feature_d;
            cmp_threshold_q <= cmp_threshold_d;
            class_q         <= class_d;
            depth_out_q     <= depth_out_d;
            error_q         <= error_d;
        end
    end

    // Strobes are decoded from the state register. An asynchronous reset
    // therefore drops them at once, without waiting for a clock edge.
    always_comb begin
        busy          = (state_q != S_IDLE) && (state_q != S_DONE);
        done          = (state_q == S_DONE);
        node_rd       = (state_q == S_FETCH);
        cmp_en        = (state_q == S_CMP);
        node_addr     = addr_q;
        cmp_feature   = cmp_feature_q;
        cmp_threshold = cmp_threshold_q;
        class_out     = class_q;
        depth_out     = depth_out_q;
        error         = error_q;
    end

endmodule
